// File: rtl/point_doubling.sv
// Elliptic-curve point doubling 2P = (x3, y3) on y^2 = x^3 + a*x + b over GF(p).
// One bit-serial interleaved modular multiplier and one binary extended-Euclid
// inverter are time-shared under a single FSM; start/busy/done handshake.
module point_doubling #(
   parameter int n = 231
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] p,
   input  logic [n-1:0] a,
   input  logic [n-1:0] x1,
   input  logic [n-1:0] y1,
   output logic [n-1:0] x3,
   output logic [n-1:0] y3,
   output logic         inf,
   output logic         busy,
   output logic         done
);

   localparam int BW = (n > 1) ? $clog2(n) : 1;
   localparam int IW = $clog2(2 * n);
   localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [IW-1:0] INV_LAST = IW'(2 * n - 1);
   localparam logic [IW-1:0] INV_ONE  = IW'(1);
   localparam logic [n-1:0]  ONE      = n'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_SQ, S_NUM, S_INV, S_LAM, S_LSQ, S_XR, S_YM, S_YR, S_FIN_INF
   } state_t;

   state_t         state_reg, state_next;

   // latched operands
   logic [n-1:0]   p_reg, a_reg, x1_reg, y1_reg;
   // shared multiplier
   logic [n-1:0]   mul_a_reg, mul_b_reg, acc_reg;
   logic [BW-1:0]  bit_cnt_reg;
   // shared inverter
   logic [n-1:0]   u_reg, v_reg, g1_reg, g2_reg;
   logic [IW-1:0]  inv_cnt_reg;
   // intermediates
   logic [n-1:0]   t_reg, num_reg, lam_reg, x3r_reg;
   // outputs
   logic [n-1:0]   x3_reg, y3_reg;
   logic           inf_reg, busy_reg, done_reg;

   // combinational datapath values
   logic [n-1:0]   mul_dbl, mul_step;
   logic [n-1:0]   num_val, den_val, x3r_val, dx_val, y3_val;
   logic [n-1:0]   u_next, v_next, g1_next, g2_next, inv_val;
   logic           accept, mul_last, mul_run, inv_exit;

   // (x + y) mod m for reduced operands, evaluated in n+2 bits
   function automatic logic [n-1:0] add_mod(input logic [n-1:0] x, input logic [n-1:0] y,
                                            input logic [n-1:0] m);
      logic [n+1:0] s;
      s = {2'b00, x} + {2'b00, y};
      return (s >= {2'b00, m}) ? (s[n-1:0] - m) : s[n-1:0];
   endfunction

   // (x - y) mod m for reduced operands; borrow bit selects the add-back of m
   function automatic logic [n-1:0] sub_mod(input logic [n-1:0] x, input logic [n-1:0] y,
                                            input logic [n-1:0] m);
      logic [n:0] d;
      d = {1'b0, x} - {1'b0, y};
      return d[n] ? (d[n-1:0] + m) : d[n-1:0];
   endfunction

   // x / 2 mod m (m odd): odd x becomes (x + m) / 2 = (x >> 1) + (m >> 1) + 1
   function automatic logic [n-1:0] half_mod(input logic [n-1:0] x, input logic [n-1:0] m);
      return x[0] ? ((x >> 1) + (m >> 1) + ONE) : (x >> 1);
   endfunction

   // Datapath arithmetic: multiplier step, field formulas and one inverter step
   always_comb begin
      mul_dbl  = add_mod(acc_reg, acc_reg, p_reg);
      mul_step = mul_b_reg[n-1] ? add_mod(mul_dbl, mul_a_reg, p_reg) : mul_dbl;

      num_val  = add_mod(add_mod(add_mod(t_reg, t_reg, p_reg), t_reg, p_reg), a_reg, p_reg);
      den_val  = add_mod(y1_reg, y1_reg, p_reg);
      x3r_val  = sub_mod(t_reg, add_mod(x1_reg, x1_reg, p_reg), p_reg);
      dx_val   = sub_mod(x1_reg, x3r_val, p_reg);
      y3_val   = sub_mod(t_reg, y1_reg, p_reg);

      // each step at least halves u*v, so a valid inverse needs under 2n steps
      u_next  = u_reg;
      v_next  = v_reg;
      g1_next = g1_reg;
      g2_next = g2_reg;
      if (!u_reg[0]) begin
         u_next  = u_reg >> 1;
         g1_next = half_mod(g1_reg, p_reg);
      end else if (!v_reg[0]) begin
         v_next  = v_reg >> 1;
         g2_next = half_mod(g2_reg, p_reg);
      end else if (u_reg >= v_reg) begin
         u_next  = (u_reg - v_reg) >> 1;
         g1_next = half_mod(sub_mod(g1_reg, g2_reg, p_reg), p_reg);
      end else begin
         v_next  = (v_reg - u_reg) >> 1;
         g2_next = half_mod(sub_mod(g2_reg, g1_reg, p_reg), p_reg);
      end
      inv_val = (u_reg == ONE) ? g1_reg : g2_reg;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic and control strobes
   always_comb begin
      state_next = state_reg;
      accept     = (state_reg == S_IDLE) && start && !busy_reg;
      mul_last   = (bit_cnt_reg == '0);
      mul_run    = (state_reg == S_SQ) || (state_reg == S_LAM) ||
                   (state_reg == S_LSQ) || (state_reg == S_YM);
      // the cycle cap only matters for out-of-range inputs that never converge
      inv_exit   = (u_reg == ONE) || (v_reg == ONE) || (inv_cnt_reg == INV_LAST);
      case (state_reg)
         S_IDLE:    if (accept) state_next = (y1 == '0) ? S_FIN_INF : S_SQ;
         S_SQ:      if (mul_last) state_next = S_NUM;
         S_NUM:     state_next = S_INV;
         S_INV:     if (inv_exit) state_next = S_LAM;
         S_LAM:     if (mul_last) state_next = S_LSQ;
         S_LSQ:     if (mul_last) state_next = S_XR;
         S_XR:      state_next = S_YM;
         S_YM:      if (mul_last) state_next = S_YR;
         S_YR:      state_next = S_IDLE;
         S_FIN_INF: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Datapath registers: operand latch, multiplier sequencing, inverter iteration
   always_ff @(posedge clk) begin
      if (mul_run) begin
         acc_reg     <= mul_step;
         mul_b_reg   <= mul_b_reg << 1;
         bit_cnt_reg <= bit_cnt_reg - BIT_ONE;
      end
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               p_reg       <= p;
               a_reg       <= a;
               x1_reg      <= x1;
               y1_reg      <= y1;
               mul_a_reg   <= x1;
               mul_b_reg   <= x1;
               acc_reg     <= '0;
               bit_cnt_reg <= BIT_LAST;
            end
         end
         S_SQ: begin
            if (mul_last) t_reg <= mul_step;
         end
         S_NUM: begin
            num_reg     <= num_val;
            u_reg       <= den_val;
            v_reg       <= p_reg;
            g1_reg      <= ONE;
            g2_reg      <= '0;
            inv_cnt_reg <= '0;
         end
         S_INV: begin
            if (inv_exit) begin
               mul_a_reg   <= num_reg;
               mul_b_reg   <= inv_val;
               acc_reg     <= '0;
               bit_cnt_reg <= BIT_LAST;
            end else begin
               u_reg       <= u_next;
               v_reg       <= v_next;
               g1_reg      <= g1_next;
               g2_reg      <= g2_next;
               inv_cnt_reg <= inv_cnt_reg + INV_ONE;
            end
         end
         S_LAM: begin
            if (mul_last) begin
               lam_reg     <= mul_step;
               mul_a_reg   <= mul_step;
               mul_b_reg   <= mul_step;
               acc_reg     <= '0;
               bit_cnt_reg <= BIT_LAST;
            end
         end
         S_LSQ: begin
            if (mul_last) t_reg <= mul_step;
         end
         S_XR: begin
            x3r_reg     <= x3r_val;
            mul_a_reg   <= lam_reg;
            mul_b_reg   <= dx_val;
            acc_reg     <= '0;
            bit_cnt_reg <= BIT_LAST;
         end
         S_YM: begin
            if (mul_last) t_reg <= mul_step;
         end
         default: ;
      endcase
   end

   // Result registers and handshake: done is a registered one-cycle pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         x3_reg   <= '0;
         y3_reg   <= '0;
         inf_reg  <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (accept)        busy_reg <= 1'b1;
         else if (done_reg) busy_reg <= 1'b0;
         if (state_reg == S_YR) begin
            x3_reg   <= x3r_reg;
            y3_reg   <= y3_val;
            inf_reg  <= 1'b0;
            done_reg <= 1'b1;
         end else if (state_reg == S_FIN_INF) begin
            x3_reg   <= '0;
            y3_reg   <= '0;
            inf_reg  <= 1'b1;
            done_reg <= 1'b1;
         end
      end
   end

   assign x3   = x3_reg;
   assign y3   = y3_reg;
   assign inf  = inf_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_point_doubling.sv
// Bench for point_doubling at n = 8: directed handshake/latency cases plus random
// points over several small primes, checked against a plain-integer reference.
module tb_point_doubling;

   localparam int N       = 8;
   localparam int LAT_MIN = 4 * N + 4;
   localparam int LAT_MAX = 6 * N + 4;

   logic         clk, reset, start;
   logic [N-1:0] p_in, a_in, x1_in, y1_in;
   logic [N-1:0] x3, y3;
   logic         inf, busy, done;

   int total = 0;
   int bad   = 0;

   point_doubling #(.n(N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .p     (p_in),
      .a     (a_in),
      .x1    (x1_in),
      .y1    (y1_in),
      .x3    (x3),
      .y3    (y3),
      .inf   (inf),
      .busy  (busy),
      .done  (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int mpow(input int b, input int e, input int m);
      int r = 1;
      b = b % m;
      while (e > 0) begin
         if (e % 2 == 1) r = (r * b) % m;
         b = (b * b) % m;
         e = e / 2;
      end
      return r;
   endfunction

   // Reference doubling: tangent slope with Fermat inverse, plain integer arithmetic
   task automatic model(input int m, input int ca, input int x, input int y,
                        output int ex, output int ey, output bit einf);
      int lam;
      if (y == 0) begin
         ex = 0; ey = 0; einf = 1'b1;
      end else begin
         lam  = ((3 * x * x + ca) % m) * mpow((2 * y) % m, m - 2, m) % m;
         ex   = ((lam * lam - 2 * x) % m + m) % m;
         ey   = ((lam * ((x - ex + m) % m) - y) % m + m) % m;
         einf = 1'b0;
      end
   endtask

   // Issues one request (called at a negedge); returns at the negedge of the cycle after done
   task automatic run_op(input int pp, input int pa, input int px, input int py,
                         input bit hold, input string tag);
      int ex, ey, lat;
      bit einf, seen, held;
      logic [N-1:0] prev_x3, prev_y3;
      logic [N-1:0] v8;
      model(pp, pa, px, py, ex, ey, einf);
      prev_x3 = x3;
      prev_y3 = y3;
      held    = 1'b1;
      v8 = pp[N-1:0]; p_in  = v8;
      v8 = pa[N-1:0]; a_in  = v8;
      v8 = px[N-1:0]; x1_in = v8;
      v8 = py[N-1:0]; y1_in = v8;
      start = 1'b1;
      @(negedge clk);
      if (hold) begin
         x1_in = 8'd0;
         y1_in = 8'd6;
      end else begin
         start = 1'b0;
      end
      check({tag, " busy_after_start"}, busy, 1);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= LAT_MAX + 4) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (x3 !== prev_x3 || y3 !== prev_y3) held = 1'b0;
            @(negedge clk);
            lat++;
         end
      end
      start = 1'b0;
      check({tag, " done_seen"}, seen, 1);
      if (einf) check({tag, " latency"}, lat, 2);
      else      check({tag, " latency_in_range"}, (lat >= LAT_MIN && lat <= LAT_MAX), 1);
      check({tag, " x3"}, x3, ex);
      check({tag, " y3"}, y3, ey);
      check({tag, " inf"}, inf, einf);
      check({tag, " x3_lt_p"}, (x3 < pp), 1);
      check({tag, " y3_lt_p"}, (y3 < pp), 1);
      check({tag, " busy_in_done"}, busy, 1);
      check({tag, " prev_result_held"}, held, 1);
      $display("op %s p=%0d a=%0d P=(%0d,%0d) -> (%0d,%0d) inf=%0d latency=%0d",
               tag, pp, pa, px, py, x3, y3, inf, lat);
      @(negedge clk);
      check({tag, " single_done"}, done, 0);
      check({tag, " busy_dropped"}, busy, 0);
      check({tag, " x3_stable"}, x3, ex);
      check({tag, " y3_stable"}, y3, ey);
   endtask

   int primes[12] = '{5, 7, 11, 13, 17, 19, 23, 97, 131, 191, 241, 251};

   initial begin
      bit no_done;
      int rp, ra, rx, ry;
      reset = 1'b1;
      start = 1'b0;
      p_in = '0; a_in = '0; x1_in = '0; y1_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset x3", x3, 0);
      check("reset y3", y3, 0);
      check("reset inf", inf, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);

      // directed cases on p = 17, a = 2; the second request lands in the cycle after done
      run_op(17, 2, 5, 1, 1'b0, "t1");
      run_op(17, 2, 6, 3, 1'b0, "t2");
      run_op(17, 2, 3, 0, 1'b0, "t3");
      run_op(17, 2, 5, 1, 1'b1, "t4_start_held");

      // abort in the inverter phase
      p_in = 8'd17; a_in = 8'd2; x1_in = 8'd5; y1_in = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (N + 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5 busy_after_reset", busy, 0);
      check("t5 x3_after_reset", x3, 0);
      check("t5 y3_after_reset", y3, 0);
      check("t5 done_after_reset", done, 0);
      no_done = 1'b1;
      for (int i = 0; i < 8 * N; i++) begin
         if (done === 1'b1 || busy === 1'b1) no_done = 1'b0;
         @(negedge clk);
      end
      check("t5 no_done_after_abort", no_done, 1);
      run_op(17, 2, 5, 1, 1'b0, "t5_fresh");

      // random points; any (x, y) lies on the curve whose b makes the equation hold
      for (int k = 0; k < 300; k++) begin
         rp = primes[$urandom_range(0, 11)];
         ra = int'($urandom_range(0, rp - 1));
         rx = int'($urandom_range(0, rp - 1));
         ry = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, rp - 1));
         run_op(rp, ra, rx, ry, 1'b0, $sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
